// File: rtl/rob_pkg.sv
// rob_pkg: shared widths and index/count types for the reorder buffer
package rob_pkg;
    localparam int ROB_ID_WIDTH   = 4;
    localparam int ROB_DATA_WIDTH = 8;
    localparam int ROB_DEPTH      = 1 << ROB_ID_WIDTH;
    typedef logic [ROB_ID_WIDTH-1:0] rob_id_t;
    typedef logic [ROB_ID_WIDTH:0]   rob_cnt_t;
endpackage

// File: rtl/mem_2ps.sv
// mem_2ps: one-write one-read memory with a registered read port
module mem_2ps #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  write_en_i,
    input  logic [ADDR_WIDTH-1:0] addr_write_i,
    input  logic [DATA_WIDTH-1:0] data_write_i,
    input  logic [ADDR_WIDTH-1:0] addr_read_i,
    output logic [DATA_WIDTH-1:0] data_read_o
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    // store the incoming payload
    always_ff @(posedge clk) begin
        if (write_en_i) mem[addr_write_i] <= data_write_i;
    end
    // read register; same-address write in the same cycle returns old data
    always_ff @(posedge clk) begin
        data_read_o <= mem[addr_read_i];
    end
endmodule

// File: rtl/rob_core.sv
// rob_core: reorder buffer control, in-order alloc/retire with out-of-order writeback
module rob_core
    import rob_pkg::*;
#(
    parameter int ID_WIDTH   = ROB_ID_WIDTH,
    parameter int DATA_WIDTH = ROB_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  alloc_valid_i,
    output logic                  alloc_ready_o,
    output logic [ID_WIDTH-1:0]   alloc_id_o,
    input  logic                  wb_valid_i,
    input  logic [ID_WIDTH-1:0]   wb_id_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ID_WIDTH-1:0]   out_id_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [ID_WIDTH:0]     count_o,
    output logic                  err_o
);
    localparam int DEPTH = 1 << ID_WIDTH;
    localparam logic [ID_WIDTH:0] FULL = (ID_WIDTH+1)'(DEPTH);

    logic [ID_WIDTH-1:0] tail_ptr, head_ptr, out_id_q;
    logic [DEPTH-1:0]    pending, done, pending_d, done_d;
    logic [ID_WIDTH:0]   count;
    logic                out_valid_q, err_q;
    logic                alloc_fire, wb_accept, stage_free, fire_rd, retire;

    assign alloc_ready_o = count != FULL;
    assign alloc_fire    = alloc_valid_i && alloc_ready_o;
    assign wb_accept     = wb_valid_i && pending[wb_id_i];
    assign stage_free    = !out_valid_q || out_ready_i;
    assign fire_rd       = done[head_ptr] && stage_free;
    assign retire        = out_valid_q && out_ready_i;

    assign alloc_id_o  = tail_ptr;
    assign out_valid_o = out_valid_q;
    assign out_id_o    = out_id_q;
    assign count_o     = count;
    assign err_o       = err_q;

    // per-entry status: alloc sets pending, writeback moves it to done, launch clears done
    always_comb begin
        pending_d = pending;
        done_d    = done;
        if (alloc_fire) pending_d[tail_ptr] = 1'b1;
        if (wb_accept) begin
            pending_d[wb_id_i] = 1'b0;
            done_d[wb_id_i]    = 1'b1;
        end
        if (fire_rd) done_d[head_ptr] = 1'b0;
    end

    // pointers, output stage, occupancy and error pulse; flush behaves like reset
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            tail_ptr    <= '0;
            head_ptr    <= '0;
            out_id_q    <= '0;
            out_valid_q <= 1'b0;
            count       <= '0;
            err_q       <= 1'b0;
            pending     <= '0;
            done        <= '0;
        end else begin
            tail_ptr    <= alloc_fire ? tail_ptr + ID_WIDTH'(1) : tail_ptr;
            head_ptr    <= fire_rd ? head_ptr + ID_WIDTH'(1) : head_ptr;
            out_id_q    <= fire_rd ? head_ptr : out_id_q;
            out_valid_q <= fire_rd || (out_valid_q && !out_ready_i);
            count       <= count + (ID_WIDTH+1)'(alloc_fire) - (ID_WIDTH+1)'(retire);
            err_q       <= wb_valid_i && !wb_accept;
            pending     <= pending_d;
            done        <= done_d;
        end
    end

    // reading out_id_q when not launching keeps the presented payload stable under backpressure
    mem_2ps #(
        .ADDR_WIDTH(ID_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mem (
        .clk         (clk),
        .write_en_i  (wb_accept && !flush_i && !rst),
        .addr_write_i(wb_id_i),
        .data_write_i(wb_data_i),
        .addr_read_i (fire_rd ? head_ptr : out_id_q),
        .data_read_o (out_data_o)
    );
endmodule

// File: tb/tb_rob_core.sv
// tb_rob_core: directed scenarios plus randomized run against a queue-based reorder model
module tb_rob_core;
    import rob_pkg::*;

    logic clk = 1'b0;
    logic rst, flush_i, alloc_valid_i, wb_valid_i, out_ready_i;
    rob_id_t wb_id_i, alloc_id_o, out_id_o;
    logic [7:0] wb_data_i, out_data_o;
    logic alloc_ready_o, out_valid_o, err_o;
    rob_cnt_t count_o;
    int cmp = 0;
    int bad = 0;

    always #5 clk = ~clk;

    rob_core dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o), .alloc_id_o(alloc_id_o),
        .wb_valid_i(wb_valid_i), .wb_id_i(wb_id_i), .wb_data_i(wb_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_id_o(out_id_o),
        .out_data_o(out_data_o), .count_o(count_o), .err_o(err_o)
    );

    task automatic idle();
        rst = 1'b0; flush_i = 1'b0; alloc_valid_i = 1'b0; wb_valid_i = 1'b0;
        out_ready_i = 1'b0; wb_id_i = '0; wb_data_i = '0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        cmp++;
        if ({alloc_ready_o, alloc_id_o, count_o, out_valid_o, err_o} !== {1'b1, 4'd0, 5'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state got rdy=%b id=%0d cnt=%0d ov=%b err=%b exp rdy=1 id=0 cnt=0 ov=0 err=0",
                     alloc_ready_o, alloc_id_o, count_o, out_valid_o, err_o);
        end
    endtask

    task automatic test_alloc3();
        do_reset();
        alloc_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmp++;
            if ({alloc_ready_o, alloc_id_o, out_valid_o} !== {1'b1, 4'(i), 1'b0}) begin
                bad++;
                $display("FAIL alloc3_id%0d got rdy=%b id=%0d ov=%b exp rdy=1 id=%0d ov=0", i, alloc_ready_o, alloc_id_o, out_valid_o, i);
            end
            nxt();
        end
        alloc_valid_i = 1'b0;
        @(negedge clk);
        cmp++;
        if ({count_o, out_valid_o} !== {5'd3, 1'b0}) begin
            bad++;
            $display("FAIL alloc3_count got cnt=%0d ov=%b exp cnt=3 ov=0", count_o, out_valid_o);
        end
    endtask

    task automatic test_latency();
        logic [3:0] wid [3];
        logic [7:0] wd [3];
        logic [7:0] ed [3];
        wid = '{4'd2, 4'd0, 4'd1};
        wd  = '{8'hC2, 8'hA0, 8'hB1};
        ed  = '{8'hA0, 8'hB1, 8'hC2};
        do_reset();
        alloc_valid_i = 1'b1;
        repeat (3) nxt();
        alloc_valid_i = 1'b0;
        out_ready_i = 1'b1;
        for (int k = 0; k < 7; k++) begin
            wb_valid_i = k < 3;
            wb_id_i = k < 3 ? wid[k] : 4'd0;
            wb_data_i = k < 3 ? wd[k] : 8'd0;
            @(negedge clk);
            cmp++;
            if (k >= 3 && k <= 5) begin
                if ({out_valid_o, out_id_o, out_data_o} !== {1'b1, 4'(k-3), ed[k-3]}) begin
                    bad++;
                    $display("FAIL latency_k%0d got ov=%b id=%0d data=%h exp ov=1 id=%0d data=%h", k, out_valid_o, out_id_o, out_data_o, k-3, ed[k-3]);
                end
            end else if (out_valid_o !== 1'b0 || (k == 6 && count_o !== 5'd0)) begin
                bad++;
                $display("FAIL latency_k%0d got ov=%b cnt=%0d exp ov=0%s", k, out_valid_o, count_o, k == 6 ? " cnt=0" : "");
            end
            nxt();
        end
        idle();
    endtask

    task automatic test_backpressure();
        do_reset();
        alloc_valid_i = 1'b1;
        nxt();
        alloc_valid_i = 1'b0;
        wb_valid_i = 1'b1; wb_id_i = 4'd0; wb_data_i = 8'h5A;
        nxt();
        wb_valid_i = 1'b0;
        nxt();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmp++;
            if ({out_valid_o, out_id_o, out_data_o, count_o} !== {1'b1, 4'd0, 8'h5A, 5'd1}) begin
                bad++;
                $display("FAIL hold_c%0d got ov=%b id=%0d data=%h cnt=%0d exp ov=1 id=0 data=5a cnt=1", i, out_valid_o, out_id_o, out_data_o, count_o);
            end
            nxt();
        end
        out_ready_i = 1'b1;
        nxt();
        out_ready_i = 1'b0;
        @(negedge clk);
        cmp++;
        if ({out_valid_o, count_o} !== {1'b0, 5'd0}) begin
            bad++;
            $display("FAIL hold_retire got ov=%b cnt=%0d exp ov=0 cnt=0", out_valid_o, count_o);
        end
    endtask

    task automatic test_full();
        do_reset();
        alloc_valid_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            cmp++;
            if ({alloc_ready_o, alloc_id_o} !== {1'b1, 4'(i)}) begin
                bad++;
                $display("FAIL full_alloc%0d got rdy=%b id=%0d exp rdy=1 id=%0d", i, alloc_ready_o, alloc_id_o, i);
            end
            nxt();
        end
        wb_valid_i = 1'b1; wb_id_i = 4'd0; wb_data_i = 8'h11;
        @(negedge clk);
        cmp++;
        if ({alloc_ready_o, count_o} !== {1'b0, 5'd16}) begin
            bad++;
            $display("FAIL full_stop got rdy=%b cnt=%0d exp rdy=0 cnt=16", alloc_ready_o, count_o);
        end
        nxt();
        wb_valid_i = 1'b0;
        nxt();
        out_ready_i = 1'b1;
        @(negedge clk);
        cmp++;
        if ({out_valid_o, alloc_ready_o, count_o} !== {1'b1, 1'b0, 5'd16}) begin
            bad++;
            $display("FAIL full_retire_cycle got ov=%b rdy=%b cnt=%0d exp ov=1 rdy=0 cnt=16", out_valid_o, alloc_ready_o, count_o);
        end
        nxt();
        out_ready_i = 1'b0;
        @(negedge clk);
        cmp++;
        if ({alloc_ready_o, alloc_id_o, count_o} !== {1'b1, 4'd0, 5'd15}) begin
            bad++;
            $display("FAIL full_reopen got rdy=%b id=%0d cnt=%0d exp rdy=1 id=0 cnt=15", alloc_ready_o, alloc_id_o, count_o);
        end
        nxt();
        alloc_valid_i = 1'b0;
        @(negedge clk);
        cmp++;
        if ({alloc_ready_o, alloc_id_o, count_o} !== {1'b0, 4'd1, 5'd16}) begin
            bad++;
            $display("FAIL full_wrap_grant got rdy=%b id=%0d cnt=%0d exp rdy=0 id=1 cnt=16", alloc_ready_o, alloc_id_o, count_o);
        end
    endtask

    task automatic test_err();
        int n;
        do_reset();
        alloc_valid_i = 1'b1;
        repeat (2) nxt();
        alloc_valid_i = 1'b0;
        wb_valid_i = 1'b1; wb_id_i = 4'd5; wb_data_i = 8'h77;
        nxt();
        wb_valid_i = 1'b0;
        @(negedge clk);
        cmp++;
        if (err_o !== 1'b1) begin bad++; $display("FAIL err_unalloc got %b exp 1", err_o); end
        nxt();
        wb_valid_i = 1'b1; wb_id_i = 4'd0; wb_data_i = 8'h33;
        @(negedge clk);
        cmp++;
        if (err_o !== 1'b0) begin bad++; $display("FAIL err_pulse_end got %b exp 0", err_o); end
        nxt();
        wb_data_i = 8'hFF;
        @(negedge clk);
        cmp++;
        if (err_o !== 1'b0) begin bad++; $display("FAIL err_good_wb got %b exp 0", err_o); end
        nxt();
        wb_valid_i = 1'b0;
        @(negedge clk);
        cmp++;
        if (err_o !== 1'b1) begin bad++; $display("FAIL err_dup got %b exp 1", err_o); end
        nxt();
        out_ready_i = 1'b1;
        n = 0;
        @(negedge clk);
        cmp++;
        if (err_o !== 1'b0) begin bad++; $display("FAIL err_dup_end got %b exp 0", err_o); end
        while (!out_valid_o && n < 10) begin nxt(); @(negedge clk); n++; end
        cmp++;
        if ({out_valid_o, out_id_o, out_data_o} !== {1'b1, 4'd0, 8'h33}) begin
            bad++;
            $display("FAIL err_orig_data got ov=%b id=%0d data=%h exp ov=1 id=0 data=33", out_valid_o, out_id_o, out_data_o);
        end
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        alloc_valid_i = 1'b1;
        repeat (7) nxt();
        alloc_valid_i = 1'b0;
        wb_valid_i = 1'b1; wb_id_i = 4'd0; wb_data_i = 8'h05;
        nxt();
        wb_valid_i = 1'b0;
        nxt();
        @(negedge clk);
        cmp++;
        if ({out_valid_o, count_o} !== {1'b1, 5'd7}) begin
            bad++;
            $display("FAIL flush_pre got ov=%b cnt=%0d exp ov=1 cnt=7", out_valid_o, count_o);
        end
        flush_i = 1'b1;
        nxt();
        flush_i = 1'b0;
        @(negedge clk);
        cmp++;
        if ({out_valid_o, count_o, alloc_id_o, alloc_ready_o} !== {1'b0, 5'd0, 4'd0, 1'b1}) begin
            bad++;
            $display("FAIL flush_state got ov=%b cnt=%0d id=%0d rdy=%b exp ov=0 cnt=0 id=0 rdy=1", out_valid_o, count_o, alloc_id_o, alloc_ready_o);
        end
        wb_valid_i = 1'b1; wb_id_i = 4'd3; wb_data_i = 8'h99;
        nxt();
        wb_valid_i = 1'b0;
        @(negedge clk);
        cmp++;
        if (err_o !== 1'b1) begin bad++; $display("FAIL flush_stale_wb got err=%b exp 1", err_o); end
    endtask

    task automatic test_random();
        bit pend [16];
        bit wr [16];
        logic [7:0] dat [16];
        int ord [$];
        int cnt, tail;
        bit exp_err, drain, fire, acc, ret;
        do_reset();
        cnt = 0; tail = 0; exp_err = 1'b0;
        for (int j = 0; j < 16; j++) begin pend[j] = 1'b0; wr[j] = 1'b0; dat[j] = '0; end
        for (int i = 0; i < 3000; i++) begin
            drain = i >= 2500;
            if (drain && ord.size() == 0) break;
            alloc_valid_i = !drain && ($urandom_range(0, 9) < 6);
            flush_i = !drain && ($urandom_range(0, 299) == 0);
            out_ready_i = drain || ($urandom_range(0, 9) < 7);
            wb_data_i = 8'($urandom);
            wb_valid_i = !drain && $urandom_range(0, 1) == 1;
            wb_id_i = 4'($urandom_range(0, 15));
            if (!drain && ord.size() > 0 && $urandom_range(0, 3) != 0) wb_id_i = 4'(ord[$urandom_range(0, ord.size() - 1)]);
            if (drain) begin
                foreach (ord[j]) if (!wb_valid_i && pend[ord[j]]) begin wb_valid_i = 1'b1; wb_id_i = 4'(ord[j]); end
            end
            @(negedge clk);
            cmp++;
            if ({alloc_ready_o, alloc_id_o, count_o, err_o} !== {cnt != 16, 4'(tail), 5'(cnt), exp_err}) begin
                bad++;
                $display("FAIL rand_c%0d got rdy=%b id=%0d cnt=%0d err=%b exp rdy=%b id=%0d cnt=%0d err=%b",
                         i, alloc_ready_o, alloc_id_o, count_o, err_o, cnt != 16, tail, cnt, exp_err);
            end
            if (out_valid_o) begin
                cmp++;
                if (ord.size() == 0 || !wr[ord[0]] || out_id_o !== 4'(ord[0]) || out_data_o !== dat[ord[0]]) begin
                    bad++;
                    $display("FAIL rand_out_c%0d got id=%0d data=%h exp id=%0d data=%h written=%b",
                             i, out_id_o, out_data_o, ord.size() ? ord[0] : -1, ord.size() ? dat[ord[0]] : 8'h0, ord.size() ? wr[ord[0]] : 1'b0);
                end
            end
            ret = out_valid_o && out_ready_i;
            fire = alloc_valid_i && cnt != 16;
            acc = wb_valid_i && pend[wb_id_i];
            if (flush_i) begin
                for (int j = 0; j < 16; j++) begin pend[j] = 1'b0; wr[j] = 1'b0; end
                ord.delete();
                cnt = 0; tail = 0; exp_err = 1'b0;
            end else begin
                exp_err = wb_valid_i && !acc;
                if (acc) begin pend[wb_id_i] = 1'b0; wr[wb_id_i] = 1'b1; dat[wb_id_i] = wb_data_i; end
                if (ret && ord.size() > 0) begin wr[ord[0]] = 1'b0; void'(ord.pop_front()); cnt--; end
                if (fire) begin pend[tail] = 1'b1; ord.push_back(tail); tail = (tail + 1) % 16; cnt++; end
            end
            nxt();
        end
        idle();
        @(negedge clk);
        cmp++;
        if ({count_o, out_valid_o} !== {5'd0, 1'b0}) begin
            bad++;
            $display("FAIL rand_drain got cnt=%0d ov=%b exp cnt=0 ov=0", count_o, out_valid_o);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alloc3();
        test_latency();
        test_backpressure();
        test_full();
        test_err();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule

// File: doc/rob_core.md
Name: rob_core

Overview:
- Reorder buffer controller wrapping one `mem_2ps` instance as payload storage.
- Allocates sequential entry IDs in program order and accepts out-of-order writebacks by ID into storage.
- Retires entries strictly in order through a valid/ready output port.
- Sits between dispatch (allocation), execution units (writeback) and commit logic (retire).

Parameters:
- ID_WIDTH, 4, entry-index width; DEPTH = 2**ID_WIDTH entries.
- DATA_WIDTH, 8, payload width per entry.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `flush_i`  in  1  synchronous clear of all entries; priority over every other input.
- `alloc_valid_i`  in  1  dispatch requests one entry.
- `alloc_ready_o`  out  1  entry available (= count_o != DEPTH).
- `alloc_id_o`  out  ID_WIDTH  ID granted when alloc_valid_i && alloc_ready_o.
- `wb_valid_i`  in  1  writeback strobe.
- `wb_id_i`  in  ID_WIDTH  entry being completed.
- `wb_data_i`  in  DATA_WIDTH  result payload.
- `out_valid_o`  out  1  oldest completed entry presented.
- `out_ready_i`  in  1  commit accepts the presented entry.
- `out_id_o`  out  ID_WIDTH  ID of the presented entry.
- `out_data_o`  out  DATA_WIDTH  payload of the presented entry, driven directly from the `mem_2ps` read data.
- `count_o`  out  ID_WIDTH+1  occupied entries.
- `err_o`  out  1  one-cycle registered pulse on a rejected writeback.

Behaviour:

State:
- tail_ptr, head_ptr, both ID_WIDTH wide, wrapping modulo DEPTH.
- pending[DEPTH]: entry allocated, result not yet written.
- done[DEPTH]: result written, entry not yet launched to output.
- out_valid_q, out_id_q, count, err_q.

Reset and flush (rst=1 or flush_i=1, at the edge):
- tail_ptr, head_ptr, count = 0; pending, done all 0; out_valid_o=0, out_id_o=0, err_o=0.
- alloc_ready_o=1 and alloc_id_o=0 in the following cycle.
- Storage contents are not cleared; out_data_o is don't-care while out_valid_o=0.

Allocation:
- alloc fire = alloc_valid_i && alloc_ready_o. On fire: pending[tail_ptr]<=1, tail_ptr<=tail_ptr+1.
- alloc_id_o = tail_ptr, combinational from the register.
- alloc_ready_o depends only on count; no combinational path from out_ready_i. A full buffer with a simultaneous retire still refuses allocation in that cycle.

Writeback:
- Accepted iff wb_valid_i && pending[wb_id_i].
- On accept: `mem_2ps` write_en_i=1; pending<=0, done<=1 at the same edge.
- Otherwise (ID not allocated, already written, or the ID being allocated in the same cycle): write_en gated off, no state change, err_o=1 in the next cycle.

Launch (stage_free = !out_valid_q || out_ready_i):
- fire_rd = done[head_ptr] && stage_free.
- On fire_rd: done[head_ptr]<=0, head_ptr<=head_ptr+1, out_valid_q<=1, out_id_q<=head_ptr.
- If out_ready_i && !fire_rd: out_valid_q<=0.
- `mem_2ps` addr_read_i = fire_rd ? head_ptr : out_id_q.
  - The memory output register reloads the presented entry every cycle, so out_data_o stays stable under backpressure with no holding register.
  - The presented slot cannot be rewritten: it is neither pending nor free until retired.

Retire:
- Retire handshake = out_valid_o && out_ready_i. This frees the slot (count decrements).
- Back-to-back: one retire per cycle when done entries are consecutive and out_ready_i=1.

Latency:
- Writeback accepted in cycle W, entry at head, stage free → fire_rd in W+1, out_valid_o=1 with correct data in W+2.
- Writeback does not bypass the memory.

Count:
- count += alloc_fire − retire; both in one cycle leaves count unchanged.
- Never exceeds DEPTH or wraps below 0 under legal stimulus.

Wrap-around:
- Pointer wrap is natural modulo DEPTH.
- Full/empty is taken from count, not from pointer equality.

Decomposition:
- Package `rob_pkg`: default ID_WIDTH/DATA_WIDTH, localparam DEPTH, typedef `rob_id_t` (logic [ID_WIDTH-1:0]), typedef `rob_cnt_t` (logic [ID_WIDTH:0]).
- Single sub-module: `mem_2ps` instance (ADDR_WIDTH=ID_WIDTH, DATA_WIDTH=DATA_WIDTH) as payload storage.
- All control logic is flat in `rob_core`.

Test Plan:
1. Reset, alloc 3 back-to-back → alloc_id_o 0,1,2; count_o=3; out_valid_o stays 0.
2. Allocate 0–2; writeback id2=0xC2 (cycle W), id0=0xA0 (W+1), id1=0xB1 (W+2), out_ready_i=1 → out (0,0xA0) at W+3, (1,0xB1) at W+4, (2,0xC2) at W+5; count_o returns to 0.
3. Presented entry (id0, 0x5A) with out_ready_i=0 for 5 cycles → out_valid_o=1, out_id_o=0, out_data_o=0x5A held every cycle; count_o unchanged; retired on the first ready cycle.
4. Allocate 16 → alloc_ready_o=0 at count 16; alloc_valid_i held, retire entry 0 → alloc_ready_o=1 the next cycle; then alloc_id_o=0 (wrap), granted.
5. Writeback to unallocated id5, then a duplicate writeback to already-written id0 with 0xFF → err_o pulses 1 cycle each; later retire of id0 still shows the original data.
6. flush_i while out_valid_o=1 and count_o=7 → next cycle out_valid_o=0, count_o=0, alloc_id_o=0; a writeback to old id3 afterwards → err_o=1.
